// File: rtl/management_rx_fifo.sv
// management_rx_fifo: single-clock receive frame buffer for the management Ethernet path.
// Stores committed MAC frames in a word RAM and exposes them through a 16-bit polled register port.
module management_rx_fifo #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LEN_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_start,
  input  logic        rx_data_valid,
  input  logic [2:0]  rx_bytes_valid,
  input  logic [31:0] rx_data,
  input  logic        rx_commit,
  input  logic        rx_drop,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [7:0]  bus_addr,
  output logic        bus_ack,
  output logic [15:0] bus_rdata,
  output logic        bus_err
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LAW     = $clog2(LEN_DEPTH);
  localparam int unsigned LW      = 11;
  localparam int unsigned MAX_LEN = 2047;
  localparam logic [7:0]  A_STAT  = 8'h00;
  localparam logic [7:0]  A_LEN   = 8'h04;
  localparam logic [7:0]  A_DATA  = 8'h08;
  localparam logic [7:0]  A_POP   = 8'h0C;
  localparam logic [7:0]  A_DROPS = 8'h10;

  logic [31:0]   ram [DEPTH];
  logic [LW-1:0] len_mem [LEN_DEPTH];
  logic [AW-1:0] wc, wt, rp;
  logic [LW-1:0] bc;
  logic          ovf;
  logic [LAW:0]  lwp, lrp;
  logic [LW-1:0] h;
  logic [15:0]   drop_count;
  logic          rd_pend, rd_err, rd_hi, rd_mask;
  logic [31:0]   ram_q;

  logic          lf_empty, lf_full, ram_full, too_long;
  logic          data_ev, wr_fire, commit_ev, commit_ok, commit_bad;
  logic [LW-1:0] head_len;
  logic [LW:0]   bc_next, hw_off;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_half;
  logic          req, data_go, data_bad, pop_fire, drops_clr;
  logic [15:0]   rdata_c;
  logic          err_c;

  assign lf_empty = (lwp == lrp);
  assign lf_full  = (lwp[LAW] != lrp[LAW]) && (lwp[LAW-1:0] == lrp[LAW-1:0]);
  assign head_len = lf_empty ? '0 : len_mem[lrp[LAW-1:0]];
  assign ram_full = (AW'(wt + AW'(1)) == rp);
  assign bc_next  = (LW+1)'(bc) + (LW+1)'(rx_bytes_valid);
  assign too_long = bc_next > (LW+1)'(MAX_LEN);
  assign hw_off   = {h, 1'b0};
  assign rd_addr  = AW'(rp + AW'(h >> 1));
  assign rd_half  = rd_hi ? ram_q[31:16] : ram_q[15:0];

  // Framing events are mutually exclusive in practice; start > drop > commit > data if not.
  assign data_ev    = rx_data_valid && !rx_start && !rx_drop && !rx_commit;
  assign wr_fire    = data_ev && !ovf && !ram_full && !too_long;
  assign commit_ev  = rx_commit && !rx_start && !rx_drop;
  assign commit_ok  = commit_ev && !ovf && (!lf_full || pop_fire);
  assign commit_bad = commit_ev && !commit_ok;

  // Register decode for a newly accepted request
  always_comb begin
    req       = (bus_rd || bus_wr) && !rd_pend;
    rdata_c   = '0;
    err_c     = 1'b0;
    data_go   = 1'b0;
    data_bad  = 1'b0;
    pop_fire  = 1'b0;
    drops_clr = 1'b0;
    if (req) begin
      if (bus_rd) begin
        case (bus_addr)
          A_STAT:  rdata_c = {15'd0, !lf_empty};
          A_LEN:   rdata_c = 16'(head_len);
          A_DATA:  begin
            if (lf_empty || hw_off >= (LW+1)'(head_len)) data_bad = 1'b1;
            else                                          data_go  = 1'b1;
          end
          A_DROPS: rdata_c = drop_count;
          default: err_c = 1'b1;
        endcase
      end else begin
        case (bus_addr)
          A_POP:   begin
            if (lf_empty) err_c    = 1'b1;
            else          pop_fire = 1'b1;
          end
          A_DROPS: drops_clr = 1'b1;
          default: err_c = 1'b1;
        endcase
      end
    end
  end

  // Write side: tentative/committed pointers, length FIFO push, drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc         <= '0;
      wt         <= '0;
      bc         <= '0;
      ovf        <= 1'b0;
      lwp        <= '0;
      drop_count <= '0;
    end else begin
      if (rx_start || rx_drop || commit_bad) begin
        wt  <= wc;
        bc  <= '0;
        ovf <= 1'b0;
      end else if (commit_ok) begin
        wc  <= wt;
        lwp <= lwp + (LAW+1)'(1);
        bc  <= '0;
      end else if (data_ev) begin
        if (wr_fire) begin
          wt <= AW'(wt + AW'(1));
          bc <= bc_next[LW-1:0];
        end else begin
          ovf <= 1'b1;
        end
      end
      if (drops_clr)                                    drop_count <= '0;
      else if (commit_bad && drop_count != 16'hFFFF)    drop_count <= drop_count + 16'd1;
    end
  end

  // Read side: bus response, halfword index, pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp        <= '0;
      lrp       <= '0;
      h         <= '0;
      rd_pend   <= 1'b0;
      rd_err    <= 1'b0;
      rd_hi     <= 1'b0;
      rd_mask   <= 1'b0;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      bus_err   <= 1'b0;
      if (rd_pend) begin
        rd_pend <= 1'b0;
        bus_ack <= 1'b1;
        bus_err <= rd_err;
        if (!rd_err) bus_rdata <= {rd_mask ? 8'h00 : rd_half[15:8], rd_half[7:0]};
      end else if (req) begin
        if (data_go || data_bad) begin
          rd_pend <= 1'b1;
          rd_err  <= data_bad;
          rd_hi   <= h[0];
          // Last halfword of an odd-length frame carries only one valid byte
          rd_mask <= ((hw_off + (LW+1)'(1)) == (LW+1)'(head_len));
          if (data_go) h <= h + LW'(1);
        end else begin
          bus_ack   <= 1'b1;
          bus_rdata <= rdata_c;
          bus_err   <= err_c;
        end
        if (pop_fire) begin
          rp  <= AW'(rp + AW'(((LW+1)'(head_len) + (LW+1)'(3)) >> 2));
          lrp <= lrp + (LAW+1)'(1);
          h   <= '0;
        end
      end
    end
  end

  // Storage arrays, no reset
  always_ff @(posedge clk) begin
    if (wr_fire)   ram[wt] <= rx_data;
    if (commit_ok) len_mem[lwp[LAW-1:0]] <= bc;
    if (data_go)   ram_q <= ram[rd_addr];
  end

endmodule

// File: tb/tb_management_rx_fifo.sv
// tb_management_rx_fifo: randomized and directed bench for management_rx_fifo against a
// frame-level model (byte queues + length queue) for DEPTH=1024 and DEPTH=16 instances.
module tb_management_rx_fifo;
  timeunit 1ns;
  timeprecision 1ps;

  localparam logic [7:0] A_STAT  = 8'h00;
  localparam logic [7:0] A_LEN   = 8'h04;
  localparam logic [7:0] A_DATA  = 8'h08;
  localparam logic [7:0] A_POP   = 8'h0C;
  localparam logic [7:0] A_DROPS = 8'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_start, rx_data_valid, rx_commit, rx_drop;
  logic [2:0]  rx_bytes_valid;
  logic [31:0] rx_data;
  logic        bus_rd, bus_wr;
  logic [7:0]  bus_addr;
  logic        ack0, ack1, err0, err1, sel;
  logic [15:0] rdata0, rdata1;
  logic        ack_m, err_m;
  logic [15:0] rdata_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  management_rx_fifo dut (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_data_valid(rx_data_valid),
    .rx_bytes_valid(rx_bytes_valid), .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_ack(ack0), .bus_rdata(rdata0), .bus_err(err0));

  management_rx_fifo #(.DEPTH(16), .LEN_DEPTH(32)) dut_s (
    .clk(clk), .rst(rst), .rx_start(rx_start), .rx_data_valid(rx_data_valid),
    .rx_bytes_valid(rx_bytes_valid), .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_ack(ack1), .bus_rdata(rdata1), .bus_err(err1));

  assign ack_m   = sel ? ack1 : ack0;
  assign err_m   = sel ? err1 : err0;
  assign rdata_m = sel ? rdata1 : rdata0;

  // Frame-level reference model
  byte unsigned m_bytes[$];
  int           m_lens[$];
  byte unsigned m_cur[$];
  int           m_cur_words, m_drops, m_h, m_depth;
  bit           m_ovf;

  logic [15:0] rd, rd_e;
  logic        er, er_e;
  int          lat;

  function automatic int mdl_used();
    int s = 0;
    foreach (m_lens[i]) s += (m_lens[i] + 3) / 4;
    return s;
  endfunction

  function automatic logic [15:0] exp_stat();
    return (m_lens.size() != 0) ? 16'd1 : 16'd0;
  endfunction

  function automatic logic [15:0] exp_len();
    return (m_lens.size() != 0) ? 16'(m_lens[0]) : 16'd0;
  endfunction

  task automatic mdl_reset();
    m_bytes.delete(); m_lens.delete(); m_cur.delete();
    m_cur_words = 0; m_drops = 0; m_h = 0; m_ovf = 1'b0;
  endtask

  task automatic mdl_start();
    m_cur.delete(); m_cur_words = 0; m_ovf = 1'b0;
  endtask

  task automatic mdl_data(input int nb, input logic [31:0] w);
    if (m_ovf) return;
    if (mdl_used() + m_cur_words == m_depth - 1 || m_cur.size() + nb > 2047) begin
      m_ovf = 1'b1;
    end else begin
      for (int k = 0; k < nb; k++) m_cur.push_back(w[8*k +: 8]);
      m_cur_words++;
    end
  endtask

  task automatic mdl_commit();
    if (!m_ovf && m_lens.size() < 32) begin
      m_lens.push_back(m_cur.size());
      foreach (m_cur[i]) m_bytes.push_back(m_cur[i]);
    end else if (m_drops < 65535) begin
      m_drops++;
    end
    mdl_start();
  endtask

  task automatic mdl_pop(output logic e);
    int len;
    if (m_lens.size() == 0) begin
      e = 1'b1;
    end else begin
      e = 1'b0;
      len = m_lens.pop_front();
      for (int i = 0; i < len; i++) void'(m_bytes.pop_front());
      m_h = 0;
    end
  endtask

  task automatic mdl_data_rd(output logic [15:0] r, output logic e);
    int len;
    logic [7:0] lo, hi;
    r = 16'd0; e = 1'b1;
    if (m_lens.size() == 0) return;
    len = m_lens[0];
    if (2 * m_h >= len) return;
    lo = m_bytes[2*m_h];
    hi = (2 * m_h + 1 < len) ? m_bytes[2*m_h+1] : 8'h00;
    r = {hi, lo}; e = 1'b0;
    m_h++;
  endtask

  // DUT drivers
  task automatic bus_op(input logic wr, input logic [7:0] addr,
                        output logic [15:0] r, output logic e, output int l);
    @(negedge clk);
    bus_addr = addr; bus_rd = !wr; bus_wr = wr;
    @(negedge clk);
    bus_rd = 1'b0; bus_wr = 1'b0;
    l = 1;
    while (ack_m !== 1'b1 && l < 8) begin
      @(negedge clk);
      l++;
    end
    r = rdata_m; e = err_m;
  endtask

  // fin: 0 commit, 1 drop, 2 leave in progress
  task automatic send_frame(input int nbytes, input bit incr, input int fin);
    logic [31:0] w;
    int nb;
    @(negedge clk); rx_start = 1'b1; mdl_start();
    @(negedge clk); rx_start = 1'b0;
    for (int i = 0; i < nbytes; i += 4) begin
      nb = (nbytes - i >= 4) ? 4 : nbytes - i;
      w = $urandom;
      if (incr) for (int k = 0; k < nb; k++) w[8*k +: 8] = 8'(i + k);
      mdl_data(nb, w);
      rx_data_valid = 1'b1; rx_bytes_valid = 3'(nb); rx_data = w;
      @(negedge clk);
      rx_data_valid = 1'b0;
    end
    if (fin == 0) begin
      rx_commit = 1'b1; mdl_commit();
      @(negedge clk); rx_commit = 1'b0;
    end else if (fin == 1) begin
      rx_drop = 1'b1; mdl_start();
      @(negedge clk); rx_drop = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    mdl_reset();
  endtask

  task automatic test_reset();
    sel = 1'b0; m_depth = 1024;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_m !== 1'b0 || rdata_m !== 16'd0 || err_m !== 1'b0) begin
      errors++; $display("FAIL reset_outputs ack=%b rdata=%h err=%b want 0/0000/0", ack_m, rdata_m, err_m);
    end
    @(negedge clk); rst = 1'b0; mdl_reset();
    bus_op(1'b0, A_STAT, rd, er, lat);
    checks++;
    if (rd !== exp_stat() || er !== 1'b0 || lat != 1) begin
      errors++; $display("FAIL reset_stat got %h/%b lat %0d want %h/0 lat 1", rd, er, lat, exp_stat());
    end
    bus_op(1'b0, A_LEN, rd, er, lat);
    checks++;
    if (rd !== exp_len() || er !== 1'b0) begin
      errors++; $display("FAIL reset_len got %h/%b want %h/0", rd, er, exp_len());
    end
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops) || er !== 1'b0) begin
      errors++; $display("FAIL reset_drops got %h/%b want %h/0", rd, er, 16'(m_drops));
    end
    mdl_data_rd(rd_e, er_e);
    bus_op(1'b0, A_DATA, rd, er, lat);
    checks++;
    if (rd !== rd_e || er !== er_e || lat != 2) begin
      errors++; $display("FAIL reset_data got %h/%b lat %0d want %h/%b lat 2", rd, er, lat, rd_e, er_e);
    end
  endtask

  task automatic test_frames_60_61();
    for (int f = 60; f <= 61; f++) begin
      send_frame(f, 1'b1, 0);
      bus_op(1'b0, A_STAT, rd, er, lat);
      checks++;
      if (rd !== exp_stat() || er !== 1'b0) begin
        errors++; $display("FAIL stat_%0d got %h/%b want %h/0", f, rd, er, exp_stat());
      end
      bus_op(1'b0, A_LEN, rd, er, lat);
      checks++;
      if (rd !== 16'(f) || rd !== exp_len() || er !== 1'b0) begin
        errors++; $display("FAIL len_%0d got %h/%b want %h/0", f, rd, er, exp_len());
      end
      for (int i = 0; i < 32; i++) begin
        mdl_data_rd(rd_e, er_e);
        bus_op(1'b0, A_DATA, rd, er, lat);
        checks++;
        if (rd !== rd_e || er !== er_e || lat != 2) begin
          errors++; $display("FAIL data_%0d[%0d] got %h/%b lat %0d want %h/%b lat 2", f, i, rd, er, lat, rd_e, er_e);
        end
      end
      mdl_pop(er_e);
      bus_op(1'b1, A_POP, rd, er, lat);
      checks++;
      if (er !== er_e || lat != 1) begin
        errors++; $display("FAIL pop_%0d got err %b lat %0d want %b lat 1", f, er, lat, er_e);
      end
    end
    // Following frame checks that POP advanced rp by ceil(LEN/4)
    send_frame(10, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      mdl_data_rd(rd_e, er_e);
      bus_op(1'b0, A_DATA, rd, er, lat);
      checks++;
      if (rd !== rd_e || er !== er_e) begin
        errors++; $display("FAIL after_pop_data[%0d] got %h/%b want %h/%b", i, rd, er, rd_e, er_e);
      end
    end
    mdl_pop(er_e);
    bus_op(1'b1, A_POP, rd, er, lat);
  endtask

  task automatic test_drop_restart();
    send_frame(20, 1'b0, 1);
    bus_op(1'b0, A_STAT, rd, er, lat);
    checks++;
    if (rd !== exp_stat()) begin
      errors++; $display("FAIL drop_stat got %h want %h", rd, exp_stat());
    end
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL drop_drops got %h want %h", rd, 16'(m_drops));
    end
    send_frame(28, 1'b0, 2);
    send_frame(64, 1'b1, 0);
    bus_op(1'b0, A_LEN, rd, er, lat);
    checks++;
    if (rd !== exp_len()) begin
      errors++; $display("FAIL restart_len got %h want %h", rd, exp_len());
    end
    for (int i = 0; i < 33; i++) begin
      mdl_data_rd(rd_e, er_e);
      bus_op(1'b0, A_DATA, rd, er, lat);
      checks++;
      if (rd !== rd_e || er !== er_e) begin
        errors++; $display("FAIL restart_data[%0d] got %h/%b want %h/%b", i, rd, er, rd_e, er_e);
      end
    end
    mdl_pop(er_e);
    bus_op(1'b1, A_POP, rd, er, lat);
    bus_op(1'b0, A_STAT, rd, er, lat);
    checks++;
    if (rd !== exp_stat()) begin
      errors++; $display("FAIL restart_only_one got %h want %h", rd, exp_stat());
    end
  endtask

  task automatic test_bad_access();
    logic       wr_v [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] ad_v [5] = '{A_POP, A_STAT, 8'h14, A_LEN, A_POP};
    for (int i = 0; i < 5; i++) begin
      bus_op(wr_v[i], ad_v[i], rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 16'd0 || lat != 1) begin
        errors++; $display("FAIL bad_access[%0d] got %h/%b lat %0d want 0000/1 lat 1", i, rd, er, lat);
      end
    end
  endtask

  task automatic test_small_depth();
    sel = 1'b1; m_depth = 16; do_reset();
    send_frame(80, 1'b1, 0);
    bus_op(1'b0, A_STAT, rd, er, lat);
    checks++;
    if (rd !== exp_stat()) begin
      errors++; $display("FAIL small_20w_stat got %h want %h", rd, exp_stat());
    end
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL small_20w_drops got %h want %h", rd, 16'(m_drops));
    end
    mdl_pop(er_e);
    bus_op(1'b1, A_POP, rd, er, lat);
    checks++;
    if (er !== er_e) begin
      errors++; $display("FAIL small_pop_empty got err %b want %b", er, er_e);
    end
    send_frame(60, 1'b0, 0);
    send_frame(4, 1'b0, 0);
    bus_op(1'b0, A_LEN, rd, er, lat);
    checks++;
    if (rd !== exp_len()) begin
      errors++; $display("FAIL small_15w_len got %h want %h", rd, exp_len());
    end
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL small_full_drops got %h want %h", rd, 16'(m_drops));
    end
    mdl_pop(er_e);
    bus_op(1'b1, A_POP, rd, er, lat);
    send_frame(7, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      mdl_data_rd(rd_e, er_e);
      bus_op(1'b0, A_DATA, rd, er, lat);
      checks++;
      if (rd !== rd_e || er !== er_e) begin
        errors++; $display("FAIL small_wrap_data[%0d] got %h/%b want %h/%b", i, rd, er, rd_e, er_e);
      end
    end
  endtask

  task automatic test_len_fifo();
    sel = 1'b0; m_depth = 1024; do_reset();
    for (int i = 0; i < 33; i++) send_frame(4, 1'b0, 0);
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL lenfifo_drops got %h want %h", rd, 16'(m_drops));
    end
    send_frame(6, 1'b0, 2);
    @(negedge clk);
    rx_commit = 1'b1; bus_addr = A_POP; bus_wr = 1'b1;
    mdl_pop(er_e); mdl_commit();
    @(negedge clk);
    rx_commit = 1'b0; bus_wr = 1'b0;
    checks++;
    if (ack_m !== 1'b1 || err_m !== er_e) begin
      errors++; $display("FAIL pop_commit_ack got ack %b err %b want 1/%b", ack_m, err_m, er_e);
    end
    for (int i = 0; i < 34; i++) begin
      bus_op(1'b0, A_LEN, rd, er, lat);
      checks++;
      if (rd !== exp_len()) begin
        errors++; $display("FAIL lenfifo_len[%0d] got %h want %h", i, rd, exp_len());
      end
      mdl_data_rd(rd_e, er_e);
      bus_op(1'b0, A_DATA, rd, er, lat);
      checks++;
      if (rd !== rd_e || er !== er_e) begin
        errors++; $display("FAIL lenfifo_data[%0d] got %h/%b want %h/%b", i, rd, er, rd_e, er_e);
      end
      mdl_pop(er_e);
      bus_op(1'b1, A_POP, rd, er, lat);
      checks++;
      if (er !== er_e) begin
        errors++; $display("FAIL lenfifo_pop[%0d] got err %b want %b", i, er, er_e);
      end
    end
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL lenfifo_drops_after got %h want %h", rd, 16'(m_drops));
    end
    bus_op(1'b1, A_DROPS, rd, er, lat);
    m_drops = 0;
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops) || er !== 1'b0) begin
      errors++; $display("FAIL drops_clear got %h/%b want %h/0", rd, er, 16'(m_drops));
    end
  endtask

  task automatic test_max_len();
    send_frame(2047, 1'b0, 0);
    bus_op(1'b0, A_LEN, rd, er, lat);
    checks++;
    if (rd !== exp_len()) begin
      errors++; $display("FAIL max_len got %h want %h", rd, exp_len());
    end
    for (int i = 0; i < 1025; i++) begin
      mdl_data_rd(rd_e, er_e);
      bus_op(1'b0, A_DATA, rd, er, lat);
      if (i < 4 || i > 1020) begin
        checks++;
        if (rd !== rd_e || er !== er_e) begin
          errors++; $display("FAIL max_data[%0d] got %h/%b want %h/%b", i, rd, er, rd_e, er_e);
        end
      end
    end
    mdl_pop(er_e);
    bus_op(1'b1, A_POP, rd, er, lat);
    send_frame(2048, 1'b0, 0);
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL over_len_drops got %h want %h", rd, 16'(m_drops));
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8, 1'b1, 0);
    send_frame(12, 1'b0, 2);
    @(negedge clk); bus_addr = A_DATA; bus_rd = 1'b1;
    @(negedge clk); bus_rd = 1'b0; rst = 1'b1;
    #1;
    checks++;
    if (ack_m !== 1'b0 || rdata_m !== 16'd0 || err_m !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs ack=%b rdata=%h err=%b want 0/0000/0", ack_m, rdata_m, err_m);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0; mdl_reset();
    bus_op(1'b0, A_STAT, rd, er, lat);
    checks++;
    if (rd !== exp_stat()) begin
      errors++; $display("FAIL mid_reset_stat got %h want %h", rd, exp_stat());
    end
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL mid_reset_drops got %h want %h", rd, 16'(m_drops));
    end
    send_frame(41, 1'b0, 0);
    for (int i = 0; i < 22; i++) begin
      mdl_data_rd(rd_e, er_e);
      bus_op(1'b0, A_DATA, rd, er, lat);
      checks++;
      if (rd !== rd_e || er !== er_e) begin
        errors++; $display("FAIL mid_reset_data[%0d] got %h/%b want %h/%b", i, rd, er, rd_e, er_e);
      end
    end
  endtask

  task automatic test_random();
    int r, n, fin, nrd;
    sel = 1'b1; m_depth = 16; do_reset();
    for (int it = 0; it < 150; it++) begin
      r   = $urandom_range(0, 9);
      n   = $urandom_range(1, 70);
      fin = (r < 7) ? 0 : (r < 8) ? 1 : 2;
      send_frame(n, 1'b0, fin);
      bus_op(1'b0, A_LEN, rd, er, lat);
      checks++;
      if (rd !== exp_len() || er !== 1'b0) begin
        errors++; $display("FAIL rnd_len[%0d] got %h/%b want %h/0", it, rd, er, exp_len());
      end
      nrd = $urandom_range(0, 12);
      for (int k = 0; k < nrd; k++) begin
        mdl_data_rd(rd_e, er_e);
        bus_op(1'b0, A_DATA, rd, er, lat);
        checks++;
        if (rd !== rd_e || er !== er_e || lat != 2) begin
          errors++; $display("FAIL rnd_data[%0d.%0d] got %h/%b lat %0d want %h/%b lat 2", it, k, rd, er, lat, rd_e, er_e);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        mdl_pop(er_e);
        bus_op(1'b1, A_POP, rd, er, lat);
        checks++;
        if (er !== er_e || lat != 1) begin
          errors++; $display("FAIL rnd_pop[%0d] got err %b lat %0d want %b lat 1", it, er, lat, er_e);
        end
      end
    end
    bus_op(1'b0, A_DROPS, rd, er, lat);
    checks++;
    if (rd !== 16'(m_drops)) begin
      errors++; $display("FAIL rnd_drops got %h want %h", rd, 16'(m_drops));
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; m_depth = 1024;
    rx_start = 1'b0; rx_data_valid = 1'b0; rx_bytes_valid = 3'd0; rx_data = 32'd0;
    rx_commit = 1'b0; rx_drop = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = 8'd0;
    mdl_reset();
    test_reset();
    test_frames_60_61();
    test_drop_restart();
    test_bad_access();
    test_small_depth();
    test_len_fifo();
    test_max_len();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
